uart_cmd_wrapper: RTL and testbench



---
 rtl/uart_cmd_wrapper.sv | 141 ++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 123 ++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: UART endpoint assembling two RX bytes into a 16-bit command and sending 8-bit responses.
// Define CMD_TIMEOUT_EN to drop a stale high byte when the low byte does not start within TIMEOUT_CYCLES.
module uart_cmd_wrapper #(
  parameter int BAUD_CYCLES = 2604,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);
  localparam int CW = $clog2(BAUD_CYCLES);
  localparam logic [CW-1:0] FULL = CW'(BAUD_CYCLES - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_CYCLES / 2 - 1);
  typedef enum logic {R_IDLE, R_BUSY} rx_t;
  typedef enum logic {WAIT_HI, WAIT_LO} as_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_t;
  rx_t rx_st, rx_nx;
  as_t st, nx;
  tx_t tx_st, tx_nx;
  logic          rx_m, rx_s, rx_tick, rx_start, byte_ok;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [3:0]    rx_idx, tx_idx;
  logic [7:0]    rx_sr, tx_sr, hi;
  logic          ld_hi, ld_cmd, timeout, tx_tick;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      rx_st <= R_IDLE;
      st    <= WAIT_HI;
      tx_st <= T_IDLE;
    end else begin
      rx_m  <= RX;
      rx_s  <= rx_m;
      rx_st <= rx_nx;
      st    <= nx;
      tx_st <= tx_nx;
    end
  end
  // A high start bit ends the frame early as a false start
  assign rx_tick = rx_st == R_BUSY && rx_cnt == '0;
  always_comb begin
    rx_nx = rx_st == R_IDLE ? (rx_s ? R_IDLE : R_BUSY)
          : (rx_tick && (rx_idx == 4'd9 || (rx_idx == 4'd0 && rx_s))) ? R_IDLE : R_BUSY;
  end
  always_comb begin
    rx_start = rx_st == R_IDLE && !rx_s;
    byte_ok  = rx_tick && rx_idx == 4'd9 && rx_s;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sr  <= '0;
    end else if (rx_start) begin
      rx_cnt <= HALF;
      rx_idx <= '0;
    end else if (rx_tick) begin
      rx_cnt <= FULL;
      rx_idx <= rx_idx + 4'd1;
      if (rx_idx != 4'd0 && rx_idx != 4'd9) rx_sr <= {rx_s, rx_sr[7:1]};
    end else if (rx_st == R_BUSY) begin
      rx_cnt <= rx_cnt - CW'(1);
    end
  end
  always_comb begin
    nx = st == WAIT_HI ? (byte_ok ? WAIT_LO : WAIT_HI)
       : (byte_ok || timeout) ? WAIT_HI : WAIT_LO;
  end
  always_comb begin
    ld_hi  = st == WAIT_HI && byte_ok;
    ld_cmd = st == WAIT_LO && byte_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (ld_hi) hi <= rx_sr;
      if (ld_cmd) cmd <= {hi, rx_sr};
      cmd_rdy <= ld_cmd | (cmd_rdy & ~clr_cmd_rdy & ~(rx_start & st == WAIT_HI));
    end
  end
`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          lo_seen;
  always_ff @(posedge clk) begin
    if (rst || st != WAIT_LO) begin
      to_cnt  <= '0;
      lo_seen <= 1'b0;
    end else begin
      if (rx_start) lo_seen <= 1'b1;
      if (!lo_seen && !rx_start) to_cnt <= to_cnt + TW'(1);
    end
  end
  assign timeout = st == WAIT_LO && !lo_seen && !rx_start && to_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  assign tx_tick = tx_st != T_IDLE && tx_cnt == '0;
  always_comb begin
    tx_nx = tx_st == T_IDLE ? (send_resp ? T_START : T_IDLE)
          : !tx_tick ? tx_st
          : tx_st == T_START ? T_DATA
          : tx_st == T_DATA ? (tx_idx == 4'd7 ? T_STOP : T_DATA) : T_IDLE;
  end
  always_comb begin
    TX = tx_st == T_START ? 1'b0 : tx_st == T_DATA ? tx_sr[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_sr     <= '0;
      resp_sent <= 1'b0;
    end else if (tx_st == T_IDLE && send_resp) begin
      tx_sr     <= resp;
      tx_cnt    <= FULL;
      tx_idx    <= '0;
      resp_sent <= 1'b0;
    end else if (tx_tick) begin
      tx_cnt <= FULL;
      if (tx_st == T_DATA) begin
        tx_sr  <= tx_sr >> 1;
        tx_idx <= tx_idx + 4'd1;
      end
      if (tx_st == T_STOP) resp_sent <= 1'b1;
    end else if (tx_st != T_IDLE) begin
      tx_cnt <= tx_cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb_uart_cmd_wrapper: directed scoreboard bench for uart_cmd_wrapper.
module tb_uart_cmd_wrapper;
  localparam int B  = 16;
  localparam int TO = 200;
  logic        clk = 1'b0, rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent;
  logic [15:0] cmd;
  logic [7:0]  resp;
  int n_assert = 0, n_fail = 0;
  logic [15:0] exp_q[$];
  logic        bit_q[$];

  uart_cmd_wrapper #(.BAUD_CYCLES(B), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic wait_rdy(input string tag);
    for (int i = 0; i < 2 * B && !cmd_rdy; i++) @(negedge clk);
    chk(tag, cmd_rdy, 1);
    chk(tag, cmd, exp_q.pop_front());
  endtask

  initial begin
    logic [9:0] fr;
    int d;
    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      repeat (B) @(negedge clk);
      chk("reset_idle", {TX, cmd_rdy, resp_sent, cmd}, {1'b1, 1'b0, 1'b0, 16'h0000});
    end
    exp_q.push_back(16'h2000);
    send_byte(8'h20);
    send_byte(8'h00);
    wait_rdy("cmd_2000");
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("clr_rdy", cmd_rdy, 0);
    chk("clr_cmd_hold", cmd, 16'h2000);
    resp = 8'hA5;
    fr = {1'b1, resp, 1'b0};
    for (int i = 0; i < 10; i++) bit_q.push_back(fr[i]);
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    d = 7;
    for (int k = 0; k < 10; k++) begin
      repeat (d) @(negedge clk);
      d = 16;
      chk($sformatf("tx_bit%0d", k), TX, bit_q.pop_front());
      if (k == 4) begin
        chk("resp_sent_mid", resp_sent, 0);
        resp = 8'hFF;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        d = 15;
      end
    end
    for (int i = 0; i < 20 && !resp_sent; i++) @(negedge clk);
    chk("resp_sent", resp_sent, 1);
    repeat (2 * B) @(negedge clk);
    chk("tx_no_restart", {TX, resp_sent}, 2'b11);
    exp_q.push_back(16'h4002);
    send_byte(8'h40);
    send_byte(8'h55, 1'b0);
    chk("frame_err_cmd", {cmd_rdy, cmd}, {1'b0, 16'h2000});
    send_byte(8'h02);
    wait_rdy("cmd_4002");
    send_byte(8'h60);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst", {cmd_rdy, cmd}, {1'b0, 16'h0000});
    exp_q.push_back(16'h0001);
    send_byte(8'h00);
    send_byte(8'h01);
    wait_rdy("cmd_0001");
`ifdef CMD_TIMEOUT_EN
    exp_q.push_back(16'h4001);
    d = 1;
`else
    exp_q.push_back(16'h2340);
    d = 0;
`endif
    send_byte(8'h23);
    repeat (TO + 10) @(negedge clk);
    send_byte(8'h40);
    send_byte(8'h01);
    chk("timeout_rdy", cmd_rdy, d);
    chk("timeout_cmd", cmd, exp_q.pop_front());
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
